// File: rtl/flag_unit.sv
// Architectural N/V/Z flag register feeding branch PC-select, with ID/EX flag-hazard stall and stall counter.
// Optional macro FLAG_BYPASS_EN: forward next flags combinationally and never stall.
module flag_unit #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_flush,
    input  logic [3:0]        ex_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovfl,
    input  logic              id_is_branch,
    input  logic [2:0]        id_cond,
    output logic [2:0]        flags_out,
    output logic              branch_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_ROR  = 4'b0110;
    localparam logic [2:0] COND_AL = 3'b111;

    logic [2:0] flag_reg;
    logic [2:0] next_flags;
    logic [2:0] merged_flags;
    logic       full_set;
    logic       z_only;
    logic       ex_upd;
    logic       id_needs;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        full_set     = (ex_op == OP_ADD) || (ex_op == OP_SUB);
        z_only       = (ex_op == OP_XOR) || (ex_op == OP_SLL) ||
                       (ex_op == OP_SRA) || (ex_op == OP_ROR);
        ex_upd       = ex_valid & ~ex_flush & (full_set | z_only);
        id_needs     = id_is_branch & (id_cond != COND_AL);
        next_flags   = {alu_result[DATA_W-1], alu_ovfl, (alu_result == '0)};
        // Z-only ops keep the architectural N and V.
        merged_flags = full_set ? next_flags : {flag_reg[2:1], next_flags[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_reg <= 3'b000;
        end else if (ex_upd) begin
            flag_reg <= merged_flags;
        end
    end

`ifdef FLAG_BYPASS_EN
    always_comb begin
        flags_out    = rst ? 3'b000 : (ex_upd ? merged_flags : flag_reg);
        branch_stall = 1'b0;
    end
`else
    // One stall cycle suffices: the flags land in the register at the stall edge.
    always_comb begin
        flags_out    = flag_reg;
        branch_stall = ~rst & id_needs & ex_upd;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (branch_stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_flag_unit.sv
// Testbench for flag_unit: vector table with scoreboard, plus reset and counter-saturation sequences.
module tb_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_flush;
    logic [3:0]  ex_op;
    logic [15:0] alu_result;
    logic        alu_ovfl;
    logic        id_is_branch;
    logic [2:0]  id_cond;
    logic [2:0]  flags_out;
    logic        branch_stall;
    logic [15:0] stall_cnt;

    flag_unit #(.DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_op(ex_op), .alu_result(alu_result), .alu_ovfl(alu_ovfl),
        .id_is_branch(id_is_branch), .id_cond(id_cond),
        .flags_out(flags_out), .branch_stall(branch_stall), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        f;
        logic [3:0]  op;
        logic [15:0] res;
        logic        ov;
        logic        br;
        logic [2:0]  cond;
        logic        e_upd;
        logic        e_stall;
        logic [2:0]  e_flags;
    } vec_t;

    typedef struct {
        logic [2:0]  flags;
        logic [15:0] cnt;
    } exp_t;

    vec_t  vecs[18];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [2:0]  prev_flags;
    logic [15:0] exp_cnt;
    logic        stall_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [3:0] op, input logic [15:0] res,
                         input logic ov, input logic br, input logic [2:0] cond);
        ex_valid = v; ex_flush = f; ex_op = op; alu_result = res;
        alu_ovfl = ov; id_is_branch = br; id_cond = cond;
    endtask

    initial begin
`ifdef FLAG_BYPASS_EN
        stall_on = 1'b0;
`else
        stall_on = 1'b1;
`endif
        //           v     f     op     res       ov    br    cond   upd   stall flags
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 16'h8000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'b110};
        vecs[1]  = '{1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b001};
        vecs[2]  = '{1'b1, 1'b0, 4'h0, 16'h8000, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 3'b110};
        vecs[3]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b111};
        vecs[4]  = '{1'b1, 1'b0, 4'h4, 16'h0004, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b110};
        vecs[5]  = '{1'b1, 1'b0, 4'h5, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b111};
        vecs[6]  = '{1'b1, 1'b0, 4'h6, 16'h8001, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'b110};
        vecs[7]  = '{1'b1, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'b110};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'b110};
        vecs[9]  = '{1'b1, 1'b0, 4'h3, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'b110};
        vecs[10] = '{1'b1, 1'b0, 4'h7, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'b110};
        vecs[11] = '{1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 3'b001};
        vecs[12] = '{1'b0, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 3'b001};
        vecs[13] = '{1'b1, 1'b0, 4'h0, 16'h8000, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 3'b100};
        vecs[14] = '{1'b1, 1'b1, 4'h2, 16'h0005, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'b100};
        vecs[15] = '{1'b1, 1'b0, 4'h3, 16'h0000, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 3'b100};
        vecs[16] = '{1'b1, 1'b0, 4'h6, 16'h0000, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 3'b101};
        vecs[17] = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 3'b001};

        rst = 1'b1;
        drive(1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b1, 3'd1);
        #1;
        chk("reset_flags", flags_out, 3'b000);
        chk("reset_stall", branch_stall, 1'b0);
        chk("reset_cnt", stall_cnt, 16'h0000);
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        prev_flags = 3'b000;
        exp_cnt = 16'h0000;

        for (int i = 0; i < 18; i++) begin
            exp_t e;
            @(negedge clk);
            drive(vecs[i].v, vecs[i].f, vecs[i].op, vecs[i].res, vecs[i].ov, vecs[i].br, vecs[i].cond);
            #1;
            chk($sformatf("v%0d_stall", i), branch_stall, vecs[i].e_stall & stall_on);
`ifdef FLAG_BYPASS_EN
            chk($sformatf("v%0d_preflags", i), flags_out, vecs[i].e_upd ? vecs[i].e_flags : prev_flags);
`else
            chk($sformatf("v%0d_preflags", i), flags_out, prev_flags);
`endif
            if (vecs[i].e_stall & stall_on) exp_cnt = exp_cnt + 16'd1;
            e.flags = vecs[i].e_flags;
            e.cnt = exp_cnt;
            sb.push_back(e);
            prev_flags = vecs[i].e_flags;
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb_empty", i), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_flags", i), flags_out, e.flags);
                chk($sformatf("v%0d_cnt", i), stall_cnt, e.cnt);
            end
        end

        // Build up flags=111 and five stall cycles, then reset in mid-cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) drive(1'b1, 1'b0, 4'h1, 16'h8000, 1'b1, 1'b1, 3'd1);
            else       drive(1'b1, 1'b0, 4'h2, 16'h0000, 1'b0, 1'b1, 3'd1);
            if (stall_on) exp_cnt = exp_cnt + 16'd1;
        end
        @(posedge clk);
        #2;
        chk("pre_reset_flags", flags_out, 3'b111);
        chk("pre_reset_cnt", stall_cnt, exp_cnt);
        rst = 1'b1;
        #1;
        chk("async_reset_flags", flags_out, 3'b000);
        chk("async_reset_cnt", stall_cnt, 16'h0000);
        chk("async_reset_stall", branch_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0);
        #1;
        chk("post_reset_flags", flags_out, 3'b000);

        // Continuous hazard long enough to saturate the counter.
        @(negedge clk);
        drive(1'b1, 1'b0, 4'h1, 16'h0000, 1'b0, 1'b1, 3'd1);
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("sat_cnt", stall_cnt, stall_on ? 16'hFFFF : 16'h0000);
        chk("sat_flags", flags_out, 3'b001);
        @(posedge clk);
        #1;
        chk("sat_hold", stall_cnt, stall_on ? 16'hFFFF : 16'h0000);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
